// File: rtl/bist_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bist_ctrl_if
//   Request/status bundle between the BIST requester and the BIST controller:
//   run request, cancel, MISR signature in; LFSR/MISR strobes and status out.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface bist_ctrl_if;
   logic        start;
   logic        abort;
   logic [7:0]  sig;
   logic        lfsr_load;
   logic        lfsr_en;
   logic        misr_clr;
   logic        misr_en;
   logic        test_mode;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] pattern_cnt;

   // Requester side: issues runs and supplies the current signature
   modport master (
      output start, abort, sig,
      input  lfsr_load, lfsr_en, misr_clr, misr_en, test_mode,
             busy, done, pass, pattern_cnt
   );

   // Controller side
   modport slave (
      input  start, abort, sig,
      output lfsr_load, lfsr_en, misr_clr, misr_en, test_mode,
             busy, done, pass, pattern_cnt
   );
endinterface
`default_nettype wire

// File: rtl/bist_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bist_ctrl
//   ALU built-in self-test sequencer: seeds the LFSR, clears the MISR, steps
//   both for N_PATTERNS cycles, flushes LAT cycles of datapath latency, then
//   compares the frozen MISR signature against GOLDEN_SIG.
//   All outputs come straight from flops; nothing combinational reaches them
//   from start/abort/sig.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module bist_ctrl #(
   parameter int          N_PATTERNS = 255,
   parameter int          LAT        = 1,
   parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
   input  logic          clk,
   input  logic          rst,
   bist_ctrl_if.slave    bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SEED    = 3'd1,
      S_RUN     = 3'd2,
      S_FLUSH   = 3'd3,
      S_COMPARE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   // Counter value seen during the final RUN / FLUSH cycle
   localparam logic [15:0] C_RUN_LAST   = 16'(N_PATTERNS - 1);
   localparam logic [3:0]  C_FLUSH_LAST = 4'((LAT > 0) ? (LAT - 1) : 0);
   localparam logic        C_HAS_FLUSH  = (LAT > 0);

   state_t      state_q, state_d;
   logic [15:0] pattern_cnt_q;
   logic [3:0]  flush_cnt_q;
   logic        lfsr_load_q, misr_clr_q, lfsr_en_q, misr_en_q;
   logic        test_mode_q, busy_q, done_q, pass_q;

   // Next-state selection; abort wins over everything outside IDLE
   always_comb begin
      state_d = state_q;
      if (bus.abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    if (bus.start) state_d = S_SEED;
            S_SEED:    state_d = S_RUN;
            S_RUN:     if (pattern_cnt_q == C_RUN_LAST)
                          state_d = C_HAS_FLUSH ? S_FLUSH : S_COMPARE;
            S_FLUSH:   if (flush_cnt_q == C_FLUSH_LAST) state_d = S_COMPARE;
            S_COMPARE: state_d = S_DONE;
            S_DONE:    if (bus.start) state_d = S_SEED;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // State, counters and output flops; outputs are decoded from the state
   // being entered so they line up with that state's cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         pattern_cnt_q <= 16'd0;
         flush_cnt_q   <= 4'd0;
         lfsr_load_q   <= 1'b0;
         misr_clr_q    <= 1'b0;
         lfsr_en_q     <= 1'b0;
         misr_en_q     <= 1'b0;
         test_mode_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_load_q <= (state_d == S_SEED);
         misr_clr_q  <= (state_d == S_SEED);
         lfsr_en_q   <= (state_d == S_RUN);
         misr_en_q   <= (state_d == S_RUN) || (state_d == S_FLUSH);
         test_mode_q <= (state_d == S_SEED) || (state_d == S_RUN) ||
                        (state_d == S_FLUSH) || (state_d == S_COMPARE);
         busy_q      <= (state_d == S_SEED) || (state_d == S_RUN) ||
                        (state_d == S_FLUSH) || (state_d == S_COMPARE);
         done_q      <= (state_d == S_DONE);

         // Pattern count: cleared entering SEED, saturating step per RUN cycle
         if (state_d == S_SEED)
            pattern_cnt_q <= 16'd0;
         else if ((state_q == S_RUN) && !bus.abort && (pattern_cnt_q != 16'hFFFF))
            pattern_cnt_q <= pattern_cnt_q + 16'd1;

         // Flush counter only runs inside FLUSH, so it starts at 0 each time
         if (state_q == S_FLUSH)
            flush_cnt_q <= flush_cnt_q + 4'd1;
         else
            flush_cnt_q <= 4'd0;

         // Verdict captured at the end of COMPARE; dropped on restart or abort
         if ((state_d == S_SEED) || (state_d == S_IDLE))
            pass_q <= 1'b0;
         else if (state_q == S_COMPARE)
            pass_q <= (bus.sig == GOLDEN_SIG);
      end
   end

   assign bus.lfsr_load   = lfsr_load_q;
   assign bus.misr_clr    = misr_clr_q;
   assign bus.lfsr_en     = lfsr_en_q;
   assign bus.misr_en     = misr_en_q;
   assign bus.test_mode   = test_mode_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.pass        = pass_q;
   assign bus.pattern_cnt = pattern_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bist_ctrl
//   Three controller instances with different N/LAT/golden values, checked
//   cycle by cycle against a timeline model of a run.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_bist_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bist_ctrl_if if0 ();
   bist_ctrl_if if1 ();
   bist_ctrl_if if2 ();

   bist_ctrl #(.N_PATTERNS(4),  .LAT(1), .GOLDEN_SIG(8'hA5)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   bist_ctrl #(.N_PATTERNS(1),  .LAT(0), .GOLDEN_SIG(8'h3C)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   bist_ctrl #(.N_PATTERNS(16), .LAT(1), .GOLDEN_SIG(8'h5A)) dut2 (.clk(clk), .rst(rst), .bus(if2));

   logic        start_v [3];
   logic        abort_v [3];
   logic [7:0]  sig_v   [3];
   logic [23:0] obs     [3];

   assign if0.start = start_v[0];
   assign if0.abort = abort_v[0];
   assign if0.sig   = sig_v[0];
   assign if1.start = start_v[1];
   assign if1.abort = abort_v[1];
   assign if1.sig   = sig_v[1];
   assign if2.start = start_v[2];
   assign if2.abort = abort_v[2];
   assign if2.sig   = sig_v[2];

   // Observed vector: {lfsr_load, misr_clr, lfsr_en, misr_en, test_mode, busy, done, pass, pattern_cnt}
   assign obs[0] = {if0.lfsr_load, if0.misr_clr, if0.lfsr_en, if0.misr_en, if0.test_mode,
                    if0.busy, if0.done, if0.pass, if0.pattern_cnt};
   assign obs[1] = {if1.lfsr_load, if1.misr_clr, if1.lfsr_en, if1.misr_en, if1.test_mode,
                    if1.busy, if1.done, if1.pass, if1.pattern_cnt};
   assign obs[2] = {if2.lfsr_load, if2.misr_clr, if2.lfsr_en, if2.misr_en, if2.test_mode,
                    if2.busy, if2.done, if2.pass, if2.pattern_cnt};

   int vectors     = 0;
   int miscompares = 0;

   function automatic int np(input int k);
      case (k)
         0: return 4;
         1: return 1;
         default: return 16;
      endcase
   endfunction

   function automatic int lt(input int k);
      case (k)
         0: return 1;
         1: return 0;
         default: return 1;
      endcase
   endfunction

   function automatic logic [7:0] gs(input int k);
      case (k)
         0: return 8'hA5;
         1: return 8'h3C;
         default: return 8'h5A;
      endcase
   endfunction

   // Expected outputs during cycle t after the start edge (edge 0), from the run timeline
   function automatic logic [23:0] model(input int k, input int t, input logic pv);
      int n;
      int l;
      n = np(k);
      l = lt(k);
      if (t == 1)              return {8'b1100_1100, 16'd0};          // SEED
      if (t <= n + 1)          return {8'b0011_1100, 16'(t - 2)};     // RUN
      if (t <= n + 1 + l)      return {8'b0001_1100, 16'(n)};         // FLUSH
      if (t == n + 2 + l)      return {8'b0000_1100, 16'(n)};         // COMPARE
      return {7'b0000_001, pv, 16'(n)};                               // DONE
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete run on instance k; csig is presented during COMPARE
   task automatic run_one(input int k, input logic [7:0] csig, input bit toggle, input string name);
      int n;
      int l;
      logic pv;
      logic [23:0] e;
      n  = np(k);
      l  = lt(k);
      pv = (csig == gs(k));
      start_v[k] = 1'b1;
      tick();
      for (int t = 1; t <= n + l + 4; t++) begin
         if (toggle && (t <= n + 2 + l)) start_v[k] = 1'($urandom_range(0, 1));
         else                            start_v[k] = 1'b0;
         if (t == n + 2 + l) sig_v[k] = csig;
         else                sig_v[k] = 8'($urandom);
         e = model(k, t, pv);
         vectors++;
         if (obs[k] !== e) begin
            miscompares++;
            $display("FAIL %s t=%0d got %h exp %h", name, t, obs[k], e);
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start_v[k] = 1'b0;
         abort_v[k] = 1'b0;
         sig_v[k]   = 8'h00;
      end
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (obs[k] !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_state dut%0d got %h exp %h", k, obs[k], 24'h0);
         end
      end
      rst = 1'b1;
      tick();
      // Reset in the middle of a RUN on the 16-pattern instance
      start_v[2] = 1'b1;
      tick();
      start_v[2] = 1'b0;
      repeat (4) tick();
      vectors++;
      if (obs[2] !== model(2, 5, 1'b0)) begin
         miscompares++;
         $display("FAIL reset_prerun got %h exp %h", obs[2], model(2, 5, 1'b0));
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (obs[2] !== 24'h0) begin
         miscompares++;
         $display("FAIL reset_midrun got %h exp %h", obs[2], 24'h0);
      end
      #2;
      rst = 1'b1;
      tick();
      tick();
      vectors++;
      if (obs[2] !== 24'h0) begin
         miscompares++;
         $display("FAIL reset_idle got %h exp %h", obs[2], 24'h0);
      end
   endtask

   task automatic test_nominal_pass();
      run_one(0, 8'hA5, 1'b0, "nominal_pass");
   endtask

   task automatic test_fail();
      run_one(0, 8'hA4, 1'b0, "fail_sig");
   endtask

   task automatic test_lat0();
      run_one(1, 8'h3C, 1'b0, "lat0_pass");
      run_one(1, 8'h3D, 1'b0, "lat0_fail");
   endtask

   task automatic test_ignored_start();
      run_one(2, 8'h5A, 1'b1, "ignored_start");
   endtask

   task automatic test_abort();
      // Abort during cycle 3 of an N=4 run
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      tick();
      tick();
      abort_v[0] = 1'b1;
      tick();
      abort_v[0] = 1'b0;
      vectors++;
      if (obs[0][23:16] !== 8'h00) begin
         miscompares++;
         $display("FAIL abort_run got %h exp %h", obs[0][23:16], 8'h00);
      end
      tick();
      // start and abort together in DONE
      run_one(0, 8'hA5, 1'b0, "abort_prerun");
      start_v[0] = 1'b1;
      abort_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      abort_v[0] = 1'b0;
      vectors++;
      if (obs[0][23:16] !== 8'h00) begin
         miscompares++;
         $display("FAIL abort_done got %h exp %h", obs[0][23:16], 8'h00);
      end
      tick();
   endtask

   task automatic test_restart();
      run_one(0, 8'hA5, 1'b0, "restart_prerun");
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      vectors++;
      if (obs[0] !== model(0, 1, 1'b0)) begin
         miscompares++;
         $display("FAIL restart_seed got %h exp %h", obs[0], model(0, 1, 1'b0));
      end
      abort_v[0] = 1'b1;
      tick();
      abort_v[0] = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) begin
         int k;
         logic [7:0] cs;
         k  = int'($urandom_range(0, 2));
         cs = ($urandom_range(0, 1) == 1) ? gs(k) : 8'($urandom);
         run_one(k, cs, 1'($urandom_range(0, 1)), "random_run");
      end
   endtask

   initial begin
      test_reset();
      test_nominal_pass();
      test_fail();
      test_lat0();
      test_ignored_start();
      test_abort();
      test_restart();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
